// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states, prefetch entry, credit width.
package ifu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ifu_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifu_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// In-order prefetch FIFO of {instr, pc}; pop data is the registered head, zero read latency.
// Push while full is accepted only with a same-cycle pop; flush empties it in one cycle.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  ifu_entry_t       push_dat,
  input  logic             pop,
  output ifu_entry_t       pop_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  ifu_entry_t       mem_q [DEPTH];
  ifu_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign count   = cnt_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 fetch stage: PC, credit-limited word fetch, prefetch FIFO, {instr, pc} to decode; rsp->decode 1 cycle
// (0 cycles with IFU_BYPASS_EN defined). Fetch stalls once out_cnt + fifo_cnt reaches FIFO_DEPTH.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int SUM_W = CNT_W + 1;

  ifu_state_e       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic             req_vld_q, req_vld_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;
  logic [CNT_W-1:0] fifo_cnt, fifo_cnt_d;
  logic [SUM_W-1:0] credit_sum;
  logic [31:0]      pc_base;
  logic             issue_en, req_accept, rsp_keep, byp_take;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  ifu_entry_t       push_dat, head_dat;

  assign imem_req_valid = req_vld_q;
  assign imem_req_addr  = req_addr_q;
  assign req_accept     = req_vld_q & imem_req_ready;
  assign rsp_keep       = imem_rsp_valid & (discard_cnt_q == '0) & ~redirect_valid;

`ifdef IFU_BYPASS_EN
  assign byp_take = rsp_keep & fifo_empty;
`else
  assign byp_take = 1'b0;
`endif

  assign id_valid  = (~fifo_empty | byp_take) & ~redirect_valid;
  assign id_instr  = id_valid ? (fifo_empty ? imem_rsp_data : head_dat.instr) : NOP_INSTR;
  assign id_pc     = id_valid ? (fifo_empty ? rsp_pc_q : head_dat.pc) : 32'h0;
  assign fifo_pop  = id_valid & id_ready & ~fifo_empty;
  // A bypassed word already consumed by decode must not also land in the FIFO.
  assign fifo_push = rsp_keep & ~(byp_take & id_ready) & (~fifo_full | fifo_pop);

  assign push_dat.instr = imem_rsp_data;
  assign push_dat.pc    = rsp_pc_q;

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (fifo_push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .pop_dat  (head_dat),
    .count    (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    out_cnt_d     = out_cnt_q + CNT_W'(req_accept) - CNT_W'(imem_rsp_valid);
    discard_cnt_d = discard_cnt_q;
    rsp_pc_d      = rsp_pc_q;
    fifo_cnt_d    = fifo_cnt + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    pc_base       = fetch_pc_q;
    if (redirect_valid) begin
      // Everything still owed by memory is stale, including a request held or accepted this cycle.
      discard_cnt_d = out_cnt_q - CNT_W'(imem_rsp_valid) + CNT_W'(req_vld_q);
      rsp_pc_d      = redirect_pc & ~32'h3;
      fifo_cnt_d    = '0;
      pc_base       = redirect_pc & ~32'h3;
    end else if (imem_rsp_valid && (discard_cnt_q != '0)) begin
      discard_cnt_d = discard_cnt_q - CNT_W'(1);
    end else if (rsp_keep) begin
      rsp_pc_d = rsp_pc_q + PC_STEP;
    end

    credit_sum = SUM_W'(out_cnt_d) + SUM_W'(fifo_cnt_d);
    req_vld_d  = req_vld_q;
    req_addr_d = req_addr_q;
    fetch_pc_d = pc_base;
    if (!req_vld_q || req_accept) begin
      req_vld_d = issue_en & (credit_sum < SUM_W'(FIFO_DEPTH));
      if (req_vld_d) begin
        req_addr_d = pc_base;
        fetch_pc_d = pc_base + PC_STEP;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect_valid && (discard_cnt_d != '0)) state_d = DRAIN;
      DRAIN:   if (discard_cnt_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    issue_en = 1'b0;
    case (state_q)
      RUN, DRAIN: issue_en = 1'b1;
      default:    issue_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      req_addr_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      req_vld_q     <= 1'b0;
      out_cnt_q     <= '0;
      discard_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_addr_q    <= req_addr_d;
      rsp_pc_q      <= rsp_pc_d;
      req_vld_q     <= req_vld_d;
      out_cnt_q     <= out_cnt_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order instruction memory of programmable latency.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0100),
    .FIFO_DEPTH (4)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lat = 1;
  int          bad_instr = 0;
  int          gaps = 0;
  logic        seen_id = 1'b0;
  logic [31:0] req_log [$];
  logic [31:0] id_log [$];
  logic [31:0] pend_addr [$];
  int          pend_due [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        acc;
    logic [31:0] acc_addr;
    #1;
    acc      = imem_req_valid & imem_req_ready;
    acc_addr = imem_req_addr;
    if (acc) req_log.push_back(acc_addr);
    if (id_valid && id_ready) begin
      id_log.push_back(id_pc);
      if (id_instr !== mem_word(id_pc)) bad_instr++;
    end
    if (id_valid) seen_id = 1'b1;
    else if (seen_id) gaps++;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      pend_addr.push_back(acc_addr);
      pend_due.push_back(cyc + lat - 1);
    end
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    pend_addr.delete();
    pend_due.delete();
    req_log.delete();
    id_log.delete();
    bad_instr = 0;
    gaps      = 0;
    seen_id   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    int stale;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;

    // 1: streaming fetch, memory always ready, 1-cycle response, decode always ready
    lat = 1;
    do_reset();
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0000_0100);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'h0);
    repeat (20) tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_req%0d", i), req_log[i], 32'h100 + 32'(4 * i));
      chk($sformatf("t1_id%0d", i), id_log[i], 32'h100 + 32'(4 * i));
    end
    chk("t1_gaps", 32'(gaps), 32'h0);
    chk("t1_instr", 32'(bad_instr), 32'h0);

    // 2: decode stalled; credit stops at four fetches; reset applied mid-stream
    id_ready = 1'b0;
    do_reset();
    chk("t2_rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("t2_rst_id_valid", 32'(id_valid), 32'h0);
    repeat (15) tick();
    chk("t2_req_count", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_req%0d", i), req_log[i], 32'h100 + 32'(4 * i));
    end
    chk("t2_req_valid_low", 32'(imem_req_valid), 32'h0);
    chk("t2_head_valid", 32'(id_valid), 32'h1);
    chk("t2_head_pc", id_pc, 32'h0000_0100);
    id_ready = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_id%0d", i), id_log[i], 32'h100 + 32'(4 * i));
    end
    chk("t2_resume_addr", req_log[4], 32'h0000_0110);
    chk("t2_instr", 32'(bad_instr), 32'h0);

    // 3: redirect with fetches in flight; stale words never reach decode
    lat = 4;
    do_reset();
    k = 0;
    while (req_log.size() < 2 && k < 30) begin
      tick();
      k++;
    end
    chk("t3_wait_inflight", 32'(req_log.size() >= 2), 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2001;
    tick();
    req_log.delete();
    id_log.delete();
    bad_instr = 0;
    repeat (25) tick();
    chk("t3_req0", req_log[0], 32'h0000_2000);
    chk("t3_req1", req_log[1], 32'h0000_2004);
    chk("t3_id0", id_log[0], 32'h0000_2000);
    chk("t3_id1", id_log[1], 32'h0000_2004);
    stale = 0;
    foreach (id_log[i]) if (id_log[i] < 32'h2000) stale++;
    chk("t3_stale", 32'(stale), 32'h0);
    chk("t3_instr", 32'(bad_instr), 32'h0);

    // 4: redirect to the top word; fetch address wraps to zero
    lat = 1;
    do_reset();
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    req_log.delete();
    id_log.delete();
    repeat (10) tick();
    chk("t4_req0", req_log[0], 32'hFFFF_FFFC);
    chk("t4_req1", req_log[1], 32'h0000_0000);
    chk("t4_req2", req_log[2], 32'h0000_0004);
    chk("t4_id0", id_log[0], 32'hFFFF_FFFC);
    chk("t4_id1", id_log[1], 32'h0000_0000);

    // 5: held request stays stable across a redirect, then its response is dropped
    lat = 1;
    imem_req_ready = 1'b1;
    do_reset();
    k = 0;
    while (req_log.size() < 1 && k < 10) begin
      tick();
      k++;
    end
    chk("t5_wait_first", 32'(req_log.size()), 32'd1);
    imem_req_ready = 1'b0;
    repeat (3) tick();
    chk("t5_hold_valid", 32'(imem_req_valid), 32'h1);
    chk("t5_hold_addr", imem_req_addr, 32'h0000_0104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    tick();
    chk("t5_redir_valid", 32'(imem_req_valid), 32'h1);
    chk("t5_redir_addr", imem_req_addr, 32'h0000_0104);
    repeat (2) tick();
    chk("t5_still_addr", imem_req_addr, 32'h0000_0104);
    req_log.delete();
    id_log.delete();
    imem_req_ready = 1'b1;
    repeat (10) tick();
    chk("t5_req0", req_log[0], 32'h0000_0104);
    chk("t5_req1", req_log[1], 32'h0000_0400);
    chk("t5_req2", req_log[2], 32'h0000_0404);
    chk("t5_id0", id_log[0], 32'h0000_0400);
    chk("t5_id1", id_log[1], 32'h0000_0404);
    stale = 0;
    foreach (id_log[i]) if (id_log[i] == 32'h104) stale++;
    chk("t5_stale", 32'(stale), 32'h0);

    // 6: response latency to decode with an empty FIFO
    lat = 1;
    imem_req_ready = 1'b0;
    id_ready = 1'b1;
    do_reset();
    k = 0;
    while (!imem_req_valid && k < 10) begin
      tick();
      k++;
    end
    chk("t6_req_addr", imem_req_addr, 32'h0000_0100);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("t6_rsp_present", 32'(imem_rsp_valid), 32'h1);
`ifdef IFU_BYPASS_EN
    chk("t6_byp_valid", 32'(id_valid), 32'h1);
    chk("t6_byp_instr", id_instr, 32'h0050_0093);
    chk("t6_byp_pc", id_pc, 32'h0000_0100);
    tick();
    chk("t6_byp_consumed", 32'(id_valid), 32'h0);
`else
    chk("t6_same_cycle_valid", 32'(id_valid), 32'h0);
    chk("t6_same_cycle_instr", id_instr, 32'h0000_0013);
    tick();
    chk("t6_next_valid", 32'(id_valid), 32'h1);
    chk("t6_next_instr", id_instr, 32'h0050_0093);
    chk("t6_next_pc", id_pc, 32'h0000_0100);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
